// File: rtl/poc_stream_host.sv
`timescale 1ns/1ps
// poc_stream_host: buffers a byte stream in a FIFO and delivers each byte to
// the POC printer controller over its register bus. Each byte is handshaked
// by SR7 polling or by irq, and the handshake has a ready-wait timeout.
module poc_stream_host #(
   parameter int DW       = 8,
   parameter int DEPTH    = 16,
   parameter int SETTLE   = 50,
   parameter int POLL_GAP = 2500,
   parameter int TIMEOUT  = 250000,
   parameter int CNT_W    = 20,
   parameter int TO_W     = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     mode_int,
   input  logic                     irq,
   input  logic                     reg_out,
   output logic [DW-1:0]            data_out,
   output logic                     rw,
   output logic                     reg_in,
   output logic [2:0]               addr,
   output logic                     busy,
   output logic                     sent,
   output logic                     err_timeout,
   input  logic                     err_clr,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LV_FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_SET_MODE, S_POLL_RD, S_POLL_GAP, S_WAIT_IRQ, S_WR_DATA, S_SET_BUSY
   } state_t;

   state_t            r_state, w_nxt;
   logic [DW-1:0]     r_mem [DEPTH];
   logic [AW-1:0]     r_wp, r_rp;
   logic [AW:0]       r_level;
   logic [CNT_W-1:0]  r_cnt;
   logic [TO_W-1:0]   r_to;
   logic              r_known, r_prog, r_mode;
   logic              r_rw, r_reg_in, r_sent, r_err;
   logic [2:0]        r_addr;
   logic [DW-1:0]     r_data;

   logic w_push, w_pop, w_empty, w_set_done, w_gap_done, w_in_wait, w_to_hit;
   logic w_ld_sr0, w_ld_data, w_ld_sr7, w_ld_rd, w_to_clr, w_to_fire, w_sent;
   logic w_mode_ld, w_cnt_hold;

   assign w_empty    = (r_level == '0);
   assign s_ready    = (r_level != LV_FULL);
   assign w_push     = s_valid & s_ready;
   assign w_set_done = (r_cnt == CNT_W'(SETTLE - 1));
   assign w_gap_done = (r_cnt == CNT_W'(POLL_GAP - 1));
   assign w_in_wait  = (r_state == S_POLL_RD) || (r_state == S_POLL_GAP) ||
                       (r_state == S_WAIT_IRQ);
   assign w_to_hit   = (TIMEOUT != 0) && w_in_wait && (r_to == TO_W'(TIMEOUT - 1));
   // WAIT_IRQ settles once and then parks the counter while it waits for irq
   assign w_cnt_hold = (r_state == S_WAIT_IRQ) && w_set_done;
   assign w_ld_rd    = (w_nxt == S_POLL_RD) && (r_state != S_POLL_RD);

   assign data_out    = r_data;
   assign rw          = r_rw;
   assign reg_in      = r_reg_in;
   assign addr        = r_addr;
   assign sent        = r_sent;
   assign err_timeout = r_err;
   assign level       = r_level;
   assign busy        = (r_state != S_IDLE) || !w_empty;

   // Next-state and per-cycle control decisions
   always_comb begin
      w_nxt     = r_state;
      w_ld_sr0  = 1'b0;
      w_ld_data = 1'b0;
      w_ld_sr7  = 1'b0;
      w_to_clr  = 1'b0;
      w_to_fire = 1'b0;
      w_pop     = 1'b0;
      w_sent    = 1'b0;
      w_mode_ld = 1'b0;
      case (r_state)
         S_IDLE: if (!w_empty) begin
            w_mode_ld = 1'b1;
            w_to_clr  = 1'b1;
            if (!r_known || (mode_int != r_prog)) begin
               w_nxt    = S_SET_MODE;
               w_ld_sr0 = 1'b1;
            end else begin
               w_nxt = mode_int ? S_WAIT_IRQ : S_POLL_RD;
            end
         end
         S_SET_MODE: if (w_set_done) begin
            w_to_clr = 1'b1;
            w_nxt    = r_mode ? S_WAIT_IRQ : S_POLL_RD;
         end
         S_POLL_RD:  if (w_set_done) w_nxt = reg_out ? S_WR_DATA : S_POLL_GAP;
         S_POLL_GAP: if (w_gap_done) w_nxt = S_POLL_RD;
         S_WAIT_IRQ: if (w_set_done && !irq) w_nxt = S_WR_DATA;
         S_WR_DATA: if (w_set_done) begin
            w_nxt    = S_SET_BUSY;
            w_ld_sr7 = 1'b1;
         end
         S_SET_BUSY: if (w_set_done) begin
            w_nxt  = S_IDLE;
            w_sent = 1'b1;
         end
         default: w_nxt = S_IDLE;
      endcase
      // Ready seen in the same cycle as the timeout still delivers the byte
      if ((w_nxt == S_WR_DATA) && (r_state != S_WR_DATA)) begin
         w_ld_data = 1'b1;
         w_pop     = 1'b1;
      end else if (w_to_hit) begin
         w_nxt     = S_IDLE;
         w_pop     = 1'b1;
         w_to_fire = 1'b1;
      end
   end

   // State, delay counter, timeout counter and mode tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_to    <= '0;
         r_known <= 1'b0;
         r_prog  <= 1'b0;
         r_mode  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt != r_state) r_cnt <= '0;
         else if (!w_cnt_hold)  r_cnt <= r_cnt + CNT_W'(1);
         if (w_to_clr)       r_to <= '0;
         else if (w_in_wait) r_to <= r_to + TO_W'(1);
         if (w_mode_ld) r_mode <= mode_int;
         if (w_ld_sr0) begin
            r_known <= 1'b1;
            r_prog  <= mode_int;
         end
         if (w_to_fire)    r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   // Registered bus outputs: rw is a single-cycle strobe, addr/data/reg_in hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rw     <= 1'b0;
         r_reg_in <= 1'b0;
         r_addr   <= 3'd0;
         r_data   <= '0;
         r_sent   <= 1'b0;
      end else begin
         r_rw   <= w_ld_sr0 | w_ld_data | w_ld_sr7;
         r_sent <= w_sent;
         if (w_ld_sr0) begin
            r_addr   <= 3'd0;
            r_reg_in <= mode_int;
         end else if (w_ld_data) begin
            r_addr <= 3'd1;
            r_data <= r_mem[r_rp];
         end else if (w_ld_sr7) begin
            r_addr   <= 3'd7;
            r_reg_in <= 1'b0;
         end else if (w_ld_rd) begin
            r_addr <= 3'd7;
         end
      end
   end

   // Byte FIFO; simultaneous push and pop leave the level unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= s_data;
            r_wp        <= r_wp + AW'(1);
         end
         if (w_pop) r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: tb/tb_poc_stream_host.sv
`timescale 1ns/1ps
// Directed bench for poc_stream_host: a table of single-byte transactions
// followed by hand-written polling, irq, full-FIFO, timeout and reset sequences.
module tb_poc_stream_host;
   localparam int DW = 8, DEPTH = 4, S = 4, G = 10, TO = 1000;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic s_valid = 1'b0, mode_int = 1'b0, irq = 1'b1, reg_out = 1'b1, err_clr = 1'b0;
   logic s_ready, rw, reg_in, busy, sent, err_timeout;
   logic [DW-1:0] data_out;
   logic [2:0] addr;
   logic [$clog2(DEPTH):0] level;

   poc_stream_host #(.DW(DW), .DEPTH(DEPTH), .SETTLE(S), .POLL_GAP(G), .TIMEOUT(TO),
                     .CNT_W(8), .TO_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .mode_int(mode_int), .irq(irq), .reg_out(reg_out), .data_out(data_out), .rw(rw),
      .reg_in(reg_in), .addr(addr), .busy(busy), .sent(sent), .err_timeout(err_timeout),
      .err_clr(err_clr), .level(level));

   always #5 clk = ~clk;

   typedef struct { int cyc; logic [2:0] addr; logic ri; logic [7:0] dat; } rec_t;
   typedef struct { logic mode; logic [7:0] b; int nwr; logic sr0; } vec_t;

   rec_t wq[$];
   vec_t tv[6];
   int cyc = 0, n_sent = 0, last_sent = 0, n_tests = 0, n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: log every write strobe and every sent pulse
   always @(negedge clk) begin
      if (rw) wq.push_back('{cyc: cyc, addr: addr, ri: reg_in, dat: data_out});
      if (sent) begin
         n_sent    = n_sent + 1;
         last_sent = cyc;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic rec_t rq(input int i);
      rec_t r;
      if (i < wq.size()) r = wq[i];
      else begin
         r.cyc = -1; r.addr = 3'd4; r.ri = 1'b1; r.dat = 8'h00;
      end
      return r;
   endfunction

   // Called at a negedge; returns at a negedge. pe = edge that accepted the byte.
   task automatic push(input logic [7:0] b, output int pe);
      int n = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (!s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", s_ready, 1);
      pe = cyc + 1;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_q(input int n, input int budget, input string nm);
      int k = 0;
      while (wq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(nm, (wq.size() >= n), 1);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int pe, k0, s0, c, j;
      tv[0] = '{mode: 1'b0, b: 8'h48, nwr: 3, sr0: 1'b1};
      tv[1] = '{mode: 1'b0, b: 8'h55, nwr: 2, sr0: 1'b0};
      tv[2] = '{mode: 1'b1, b: 8'hAA, nwr: 3, sr0: 1'b1};
      tv[3] = '{mode: 1'b1, b: 8'h01, nwr: 2, sr0: 1'b0};
      tv[4] = '{mode: 1'b0, b: 8'hFF, nwr: 3, sr0: 1'b1};
      tv[5] = '{mode: 1'b0, b: 8'h00, nwr: 2, sr0: 1'b0};

      // Reset state
      irq = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rw", rw, 0);       chk("rst_addr", addr, 0);
      chk("rst_data", data_out, 0); chk("rst_regin", reg_in, 0);
      chk("rst_sent", sent, 0);   chk("rst_err", err_timeout, 0);
      chk("rst_level", level, 0); chk("rst_ready", s_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: single bytes with the POC always ready in both modes
      for (int i = 0; i < 6; i++) begin
         mode_int = tv[i].mode;
         wq.delete();
         s0 = n_sent;
         push(tv[i].b, pe);
         wait_q(tv[i].nwr, 300, $sformatf("v%0d_wait", i));
         repeat (2*S + 2) @(negedge clk);
         chk($sformatf("v%0d_nwr", i), wq.size(), tv[i].nwr);
         j = 0;
         if (tv[i].sr0) begin
            chk($sformatf("v%0d_sr0_addr", i), rq(0).addr, 0);
            chk($sformatf("v%0d_sr0_ri", i), rq(0).ri, tv[i].mode);
            j = 1;
         end
         chk($sformatf("v%0d_data_addr", i), rq(j).addr, 1);
         chk($sformatf("v%0d_data", i), rq(j).dat, tv[i].b);
         chk($sformatf("v%0d_sr7_addr", i), rq(j+1).addr, 7);
         chk($sformatf("v%0d_sr7_ri", i), rq(j+1).ri, 0);
         chk($sformatf("v%0d_settle", i), rq(j+1).cyc - rq(j).cyc, S);
         chk($sformatf("v%0d_sent", i), n_sent - s0, 1);
         chk($sformatf("v%0d_sent_t", i), last_sent - rq(j+1).cyc, S);
         chk($sformatf("v%0d_hold", i), data_out, tv[i].b);
         chk($sformatf("v%0d_busy", i), busy, 0);
      end

      // Polling: SR7 reads 0 for three polls, ready on the fourth
      mode_int = 1'b0; reg_out = 1'b0;
      wq.delete();
      push(8'h50, pe);
      k0 = pe + 1;
      wait_cyc(k0 + 2*(S+G) + S);
      chk("poll_nowr", wq.size(), 0);
      reg_out = 1'b1;
      wait_q(2, 200, "poll_wait");
      repeat (2*S + 2) @(negedge clk);
      chk("poll_nwr", wq.size(), 2);
      chk("poll_data_addr", rq(0).addr, 1);
      chk("poll_data", rq(0).dat, 8'h50);
      chk("poll_data_t", rq(0).cyc, k0 + 3*(S+G) + S);
      chk("poll_sr7", rq(1).addr, 7);

      // Interrupt mode: irq low 100 cycles after each bus write
      mode_int = 1'b1; irq = 1'b1;
      wq.delete();
      push(8'h41, pe);
      push(8'h42, pe);
      wait_q(1, 100, "irq_sr0_wait");
      chk("irq_sr0_addr", rq(0).addr, 0);
      chk("irq_sr0_ri", rq(0).ri, 1);
      repeat (100) @(negedge clk);
      irq = 1'b0; c = cyc;
      wait_q(2, 50, "irq_d0_wait");
      irq = 1'b1;
      chk("irq_d0", rq(1).dat, 8'h41);
      chk("irq_d0_t", rq(1).cyc, c + 1);
      wait_q(3, 100, "irq_sr7a_wait");
      repeat (100) @(negedge clk);
      irq = 1'b0; c = cyc;
      wait_q(4, 50, "irq_d1_wait");
      irq = 1'b1;
      wait_q(5, 100, "irq_sr7b_wait");
      repeat (2*S + 2) @(negedge clk);
      chk("irq_nwr", wq.size(), 5);
      chk("irq_d1", rq(3).dat, 8'h42);
      chk("irq_d1_t", rq(3).cyc, c + 1);
      chk("irq_sr7a", rq(2).addr, 7);
      chk("irq_sr7b", rq(4).addr, 7);

      // Fill the FIFO while not ready, then drain in order
      wq.delete();
      s0 = n_sent;
      for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), pe);
      chk("full_ready", s_ready, 0);
      chk("full_level", level, DEPTH);
      irq = 1'b0;
      for (int i = 4; i < 6; i++) push(8'h60 + 8'(i), pe);
      c = 0;
      while ((n_sent - s0) < 6 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      chk("full_drained", n_sent - s0, 6);
      j = 0;
      foreach (wq[i]) if (wq[i].addr == 3'd1) begin
         chk($sformatf("full_byte%0d", j), wq[i].dat, 8'h60 + 8'(j));
         j++;
      end
      chk("full_count", j, 6);
      chk("full_level_end", level, 0);
      irq = 1'b1;

      // Timeout: head dropped, next byte proceeds, flag sticky until cleared
      wq.delete();
      s0 = n_sent;
      push(8'h11, pe);
      k0 = pe;
      push(8'h22, pe);
      wait_cyc(k0 + TO);
      chk("to_err_before", err_timeout, 0);
      @(negedge clk);
      chk("to_err_set", err_timeout, 1);
      chk("to_level", level, 1);
      irq = 1'b0;
      wait_q(2, 200, "to_next_wait");
      repeat (2*S + 2) @(negedge clk);
      chk("to_nwr", wq.size(), 2);
      chk("to_next_data", rq(0).dat, 8'h22);
      chk("to_next_addr", rq(0).addr, 1);
      chk("to_sent", n_sent - s0, 1);
      chk("to_sticky", err_timeout, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("to_cleared", err_timeout, 0);

      // Reset while waiting for irq
      irq = 1'b1;
      push(8'h33, pe);
      push(8'h34, pe);
      repeat (20) @(negedge clk);
      chk("mid_data", data_out, 8'h22);
      chk("mid_addr", addr, 7);
      chk("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_addr", addr, 0);   chk("ar_data", data_out, 0);
      chk("ar_rw", rw, 0);       chk("ar_level", level, 0);
      chk("ar_ready", s_ready, 1); chk("ar_busy", busy, 0);
      chk("ar_err", err_timeout, 0);
      @(negedge clk);
      rst_n = 1'b1; irq = 1'b0;
      wq.delete();
      push(8'h35, pe);
      wait_q(3, 300, "ar_wait");
      repeat (2*S + 2) @(negedge clk);
      chk("ar_nwr", wq.size(), 3);
      chk("ar_sr0_addr", rq(0).addr, 0);
      chk("ar_sr0_ri", rq(0).ri, 1);
      chk("ar_d", rq(1).dat, 8'h35);
      chk("ar_sr7", rq(2).addr, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
